rf_dump_tx: RTL and testbench
=============================

# rf_dump_tx

Register-file dump transmitter for the single-cycle CPU debug path. On a start pulse it walks a range of architectural registers through the register file's `reg_sel`/`reg_data` debug read port. It snapshots each register and emits it as a 5-byte record (index, then data MSB-first) over a valid/ready byte stream toward the board's UART/display sink. It is the reading end of the debug port that the register file exposes.

## Interface
- `REG_FIRST`, default 0: first register index dumped (0..31).
- `REG_LAST`, default 31: last register index dumped. Requires `REG_FIRST <= REG_LAST <= 31`; other values are unsupported.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: dump request; sampled only in IDLE.
- `reg_sel`, output, 5: debug read address to the register file.
- `reg_data`, input, 32: debug read data, combinational from `reg_sel`; reads 0 when `reg_sel`=0.
- `tx_data`, output, 8: byte offered to the sink.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: sink accepts the byte; a transfer occurs on an edge where `tx_valid & tx_ready`.
- `busy`, output, 1: high from the cycle after `start` is accepted until the final byte is accepted.
- `done`, output, 1: one-cycle pulse after the final byte of the dump is accepted.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE; `reg_sel`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0; byte counter 0; the 40-bit record buffer is cleared.
- FSM states are IDLE, SEL and SEND.
- IDLE → SEL when `start`=1. On that edge, `reg_sel` is set to `REG_FIRST` and `busy` is set to 1. `start` is ignored in every state other than IDLE, and repeated pulses have no effect.
- SEL lasts one cycle with `tx_valid`=0, so `reg_data` settles for the current `reg_sel`.
  - On the exit edge, load the buffer with {3'b000, `reg_sel`, `reg_data`}.
  - Set the byte counter to 0, assert `tx_valid`, and go to SEND.
- SEND presents record bytes in order:
  - byte 0 = {3'b000, index};
  - bytes 1..4 = `reg_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- Handshake rules in SEND:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold stable.
  - On a transfer edge with counter < 4, advance to the next byte; `tx_valid` stays 1, so there are no bubbles within a record.
  - On a transfer edge with counter = 4 and `reg_sel` ≠ `REG_LAST`: `reg_sel` increments by 1, `tx_valid` drops to 0, and the state goes to SEL.
  - On a transfer edge with counter = 4 and `reg_sel` = `REG_LAST`: `tx_valid` drops to 0, `busy` drops to 0, `done` is 1 for the next cycle, `reg_sel` returns to 0, and the state goes to IDLE.
- Snapshot semantics: each register is sampled exactly once, at the SEL exit edge. Register-file writes after that edge do not alter bytes already buffered.
- `tx_ready` may be high while `tx_valid` is low; this has no effect.
- When `start` is held high through the `done` cycle, a new dump begins on the first IDLE cycle, i.e. the edge that ends `done`.
- Reset asserted mid-dump aborts immediately to reset values. No partial record is resumed after reset releases.

## Timing
- Start latency: `start` sampled at edge E0 → SEL in cycle E0..E1 → `tx_valid`=1 with byte 0 from E1.
- With `tx_ready` held at 1, each register costs 6 cycles: 1 SEL plus 5 transfers.
- With N = `REG_LAST`-`REG_FIRST`+1, the final transfer edge is E(6N).
- `done` is high during the cycle after E(6N).
- For the defaults (N=32), the final transfer is at E192.
- Each cycle `tx_ready` is low while `tx_valid`=1 adds exactly one cycle.
- Outputs are registered. `reg_sel` is the only value fed combinationally into the register file; nothing combinational runs from `tx_ready` to `tx_valid`.

## Test plan
- Reset values: hold `rst`=0 with random inputs. Required: `reg_sel`=0, `tx_valid`=0, `busy`=0, `done`=0. Drive `start` and release reset mid-cycle; there is no spurious transfer.
- Full dump, `tx_ready`=1, with the register-file model preloaded as rf[i]=0x1000_0000+i:
  - 160 bytes total;
  - record i = i, 0x10, 0x00, 0x00, i;
  - record 0 = 00 00 00 00 00;
  - `done` in the cycle after E192;
  - `busy` high for 192 cycles.
- Backpressure: `REG_FIRST`=`REG_LAST`=5, rf[5]=0xDEADBEEF, `tx_ready` toggling 1,0,0,1,…
  - Byte stream is 05 DE AD BE EF.
  - `tx_data` is stable on every stalled cycle.
  - The total cycle count equals 6 plus the number of stall cycles.
- Snapshot: during a dump of regs 2..3, write rf[2]=0x11111111 after reg 2's SEL exit edge. The record still carries the old value, and reg 3 is unaffected.
- Start while busy: pulse `start` in mid-dump. There is no restart, the byte sequence is unchanged, and a single `done` pulse occurs.
- Reset mid-record: assert `rst` after byte 2 of reg 7. The outputs return to reset values within the same cycle, asynchronously. A new `start` restarts at `REG_FIRST` with byte 0.

Source files
------------

// File: rtl/rf_dump_tx.sv
// Register-file dump transmitter: walks reg_sel over REG_FIRST..REG_LAST,
// snapshots each register and streams it as a 5-byte record {index, data[31:0] MSB-first}.
module rf_dump_tx #(
   parameter int unsigned REG_FIRST = 0,
   parameter int unsigned REG_LAST  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;

   localparam logic [4:0] FIRST_SEL = 5'(REG_FIRST);
   localparam logic [4:0] LAST_SEL  = 5'(REG_LAST);

   state_t      state_q, state_d;
   logic [4:0]  reg_sel_q, reg_sel_d;
   logic [39:0] buf_q, buf_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         reg_sel_q  <= 5'd0;
         buf_q      <= 40'd0;
         cnt_q      <= 3'd0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_sel_q  <= reg_sel_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      reg_sel_d  = reg_sel_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               reg_sel_d = FIRST_SEL;
               busy_d    = 1'b1;
               state_d   = SEL;
            end
         end
         SEL: begin
            // reg_data has had a full cycle to settle; this is the only sampling point
            buf_d      = {3'b000, reg_sel_q, reg_data};
            cnt_d      = 3'd0;
            tx_valid_d = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            if (tx_valid_q && tx_ready) begin
               buf_d = {buf_q[31:0], 8'h00};
               if (cnt_q != 3'd4) begin
                  cnt_d = cnt_q + 3'd1;
               end else begin
                  cnt_d      = 3'd0;
                  tx_valid_d = 1'b0;
                  if (reg_sel_q == LAST_SEL) begin
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     reg_sel_d = 5'd0;
                     state_d   = IDLE;
                  end else begin
                     reg_sel_d = reg_sel_q + 5'd1;
                     state_d   = SEL;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte on offer is always the top of the shifting record buffer
   assign tx_data  = buf_q[39:32];
   assign reg_sel  = reg_sel_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rf_dump_tx.sv
// Directed bench for rf_dump_tx: full dump with snapshot/start-while-busy,
// single-register backpressure, and asynchronous reset mid-record.
module tb_rf_dump_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, tx_ready_a, tx_valid_a, busy_a, done_a;
   logic [4:0]  reg_sel_a;
   logic [31:0] reg_data_a;
   logic [7:0]  tx_data_a;
   logic        start_b, tx_ready_b, tx_valid_b, busy_b, done_b;
   logic [4:0]  reg_sel_b;
   logic [31:0] reg_data_b;
   logic [7:0]  tx_data_b;

   logic [31:0] rf_a [32];
   logic [31:0] rf_b [32];

   assign reg_data_a = (reg_sel_a == 5'd0) ? 32'd0 : rf_a[reg_sel_a];
   assign reg_data_b = (reg_sel_b == 5'd0) ? 32'd0 : rf_b[reg_sel_b];

   rf_dump_tx u_full (
      .clk(clk), .rst(rst), .start(start_a), .reg_sel(reg_sel_a), .reg_data(reg_data_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .busy(busy_a), .done(done_a));

   rf_dump_tx #(.REG_FIRST(5), .REG_LAST(5)) u_one (
      .clk(clk), .rst(rst), .start(start_b), .reg_sel(reg_sel_b), .reg_data(reg_data_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .busy(busy_b), .done(done_b));

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0] bytes_a [$];
   logic [7:0] bytes_b [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] qa(input int idx);
      if (idx < bytes_a.size()) return bytes_a[idx];
      return 8'hxx;
   endfunction

   function automatic logic [7:0] qb(input int idx);
      if (idx < bytes_b.size()) return bytes_b[idx];
      return 8'hxx;
   endfunction

   initial begin
      int busy_cnt, done_cnt, done_k, first_edge, last_edge, byte_err;
      int stalls, stable_err, done_kb, last_b;
      logic       prev_stall;
      logic [7:0] prev_data, exp_b;
      logic [3:0] pat;

      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_ready_a = 1'b0; tx_ready_b = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rf_a[i] = 32'h1000_0000 + i;
         rf_b[i] = $urandom;
      end
      rf_b[5] = 32'hDEAD_BEEF;

      // Reset held with random inputs
      for (int k = 0; k < 5; k++) begin
         start_a = 1'($urandom); start_b = 1'($urandom);
         tx_ready_a = 1'($urandom); tx_ready_b = 1'($urandom);
         tick();
      end
      check("rst_reg_sel", reg_sel_a, 5'd0);
      check("rst_tx_valid", tx_valid_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_tx_data", tx_data_a, 8'h00);
      check("rst_b_tx_valid", tx_valid_b, 1'b0);

      // Release reset mid-cycle with start high; the following edge is E0
      start_a = 1'b1; start_b = 1'b0; tx_ready_a = 1'b1; tx_ready_b = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("release_tx_valid", tx_valid_a, 1'b0);
      check("release_busy", busy_a, 1'b0);
      tick();
      start_a = 1'b0;

      // Full dump with snapshot disturbance and a stray start in mid-dump
      busy_cnt = 0; done_cnt = 0; done_k = -1; first_edge = -1; last_edge = -1;
      for (int k = 0; k <= 200; k++) begin
         if (busy_a) busy_cnt++;
         if (done_a) begin done_cnt++; done_k = k; end
         if (k == 13) rf_a[2] = 32'h1111_1111;
         if (k == 50) start_a = 1'b1;
         if (k == 51) start_a = 1'b0;
         if (tx_valid_a && tx_ready_a) begin
            bytes_a.push_back(tx_data_a);
            if (first_edge < 0) first_edge = k + 1;
            last_edge = k + 1;
         end
         tick();
      end
      byte_err = 0;
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 5; j++) begin
            case (j)
               0:       exp_b = 8'(i);
               1:       exp_b = (i == 0) ? 8'h00 : 8'h10;
               4:       exp_b = 8'(i);
               default: exp_b = 8'h00;
            endcase
            if (qa(i * 5 + j) !== exp_b) byte_err++;
         end
      end
      check("full_byte_count", bytes_a.size(), 160);
      check("full_first_edge", first_edge, 2);
      check("full_last_edge", last_edge, 192);
      check("full_busy_cycles", busy_cnt, 192);
      check("full_done_pulses", done_cnt, 1);
      check("full_done_cycle", done_k, 192);
      check("full_byte_errors", byte_err, 0);
      check("rec0_bytes", {qa(0), qa(1), qa(2), qa(3), qa(4)}, 40'h00_0000_0000);
      check("rec2_snapshot", {qa(10), qa(11), qa(12), qa(13), qa(14)}, 40'h02_1000_0002);
      check("rec3_unaffected", {qa(15), qa(16), qa(17), qa(18), qa(19)}, 40'h03_1000_0003);
      check("full_idle_busy", busy_a, 1'b0);

      // Single register under backpressure, ready pattern 1,0,0,1 repeating
      pat = 4'b1001;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      stalls = 0; stable_err = 0; done_kb = -1; last_b = -1; prev_stall = 1'b0; prev_data = 8'h00;
      for (int k = 0; k <= 30; k++) begin
         tx_ready_b = pat[k % 4];
         if (prev_stall && (tx_data_b !== prev_data || tx_valid_b !== 1'b1)) stable_err++;
         if (done_b) done_kb = k;
         if (tx_valid_b) begin
            if (tx_ready_b) begin
               bytes_b.push_back(tx_data_b);
               last_b = k + 1;
            end else begin
               stalls++;
            end
         end
         prev_stall = tx_valid_b && !tx_ready_b;
         prev_data  = tx_data_b;
         tick();
      end
      check("bp_byte_count", bytes_b.size(), 5);
      check("bp_bytes", {qb(0), qb(1), qb(2), qb(3), qb(4)}, 40'h05_DEAD_BEEF);
      check("bp_stalls", stalls, 6);
      check("bp_last_edge", last_b, 12);
      check("bp_stable", stable_err, 0);
      check("bp_done_cycle", done_kb, 12);

      // Asynchronous reset after byte 2 of reg 7
      tx_ready_b = 1'b0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (46) tick();
      check("mid_reg_sel", reg_sel_a, 5'd7);
      check("mid_tx_valid", tx_valid_a, 1'b1);
      check("mid_busy", busy_a, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("arst_reg_sel", reg_sel_a, 5'd0);
      check("arst_tx_valid", tx_valid_a, 1'b0);
      check("arst_busy", busy_a, 1'b0);
      check("arst_done", done_a, 1'b0);
      check("arst_tx_data", tx_data_a, 8'h00);
      #1 rst = 1'b1;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      check("restart_tx_valid", tx_valid_a, 1'b1);
      check("restart_reg_sel", reg_sel_a, 5'd0);
      check("restart_byte0", tx_data_a, 8'h00);
      repeat (6) tick();
      check("restart_rec1_sel", reg_sel_a, 5'd1);
      check("restart_rec1_byte0", tx_data_a, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
